// File: rtl/pipe_stage_buffer.sv
// Generic inter-stage pipeline register with valid/ready handshake.
// Holds a control bundle and a data bundle per instruction. It can optionally
// use a two-entry skid buffer so that in_ready comes straight from a flop.
// It supports synchronous flush, bubble (NOP) conversion and a saturating
// count of squashed entries.
module pipe_stage_buffer #(
  parameter int DATA_W  = 160,
  parameter int CTRL_W  = 12,
  parameter int INSTR_W = 32,
  parameter int SKID    = 1,
  parameter int CNT_W   = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic              out_bubble,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  squash_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state;
  logic              in_ready_q;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              m_bubble;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;
  logic              s_bubble;

  logic              acc;
  logic              pop;
  logic [CTRL_W-1:0] cv_ctrl;
  logic [DATA_W-1:0] cv_data;
  logic [2:0]        squash_inc;
  logic [CNT_W+1:0]  squash_sum;

  assign out_valid  = (state != EMPTY);
  assign occupancy  = state;
  assign out_ctrl   = out_valid ? m_ctrl : '0;
  assign out_data   = out_valid ? m_data : '0;
  assign out_bubble = out_valid & m_bubble;

  // Without a skid slot the buffer can accept whenever the head leaves or is absent.
  assign in_ready = (SKID != 0) ? in_ready_q : (~out_valid | out_ready);

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  // A bubble keeps the upper data fields but zeroes control and the instruction word.
  assign cv_ctrl = in_bubble ? '0 : in_ctrl;
  assign cv_data = in_bubble ? {in_data[DATA_W-1:INSTR_W], {INSTR_W{1'b0}}} : in_data;

  // Entries lost on flush: those held and not leaving this edge, plus a beat arriving now.
  assign squash_inc = {1'b0, state} - {2'b00, pop} + {2'b00, acc};
  assign squash_sum = {2'b00, squash_cnt} + {{(CNT_W - 1){1'b0}}, squash_inc};

  // Handshake FSM: M is the head seen downstream, S catches a beat while M is stalled.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      m_ctrl     <= '0;
      m_data     <= '0;
      m_bubble   <= 1'b0;
      s_ctrl     <= '0;
      s_data     <= '0;
      s_bubble   <= 1'b0;
      squash_cnt <= '0;
    end else if (flush) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      m_ctrl     <= '0;
      m_data     <= '0;
      m_bubble   <= 1'b0;
      s_ctrl     <= '0;
      s_data     <= '0;
      s_bubble   <= 1'b0;
      if (squash_sum > {2'b00, CNT_MAX})
        squash_cnt <= CNT_MAX;
      else
        squash_cnt <= squash_sum[CNT_W-1:0];
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state    <= ONE;
            m_ctrl   <= cv_ctrl;
            m_data   <= cv_data;
            m_bubble <= in_bubble;
          end
        end
        ONE: begin
          if (acc && pop) begin
            m_ctrl   <= cv_ctrl;
            m_data   <= cv_data;
            m_bubble <= in_bubble;
          end else if (acc && (SKID != 0)) begin
            state      <= TWO;
            in_ready_q <= 1'b0;
            s_ctrl     <= cv_ctrl;
            s_data     <= cv_data;
            s_bubble   <= in_bubble;
          end else if (pop) begin
            state    <= EMPTY;
            m_ctrl   <= '0;
            m_data   <= '0;
            m_bubble <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            state      <= ONE;
            in_ready_q <= 1'b1;
            m_ctrl     <= s_ctrl;
            m_data     <= s_data;
            m_bubble   <= s_bubble;
            s_ctrl     <= '0;
            s_data     <= '0;
            s_bubble   <= 1'b0;
          end
        end
        default: begin
          state      <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
